// File: rtl/vac_cmd_conditioner.sv
// Switch conditioning for the vacuum-robot FSM: 2-flop sync, optional per-channel
// debounce (enabled by `VAC_CMD_DEBOUNCE_EN), priority one-hot command, conflict and change flags.
module vac_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_stable,
  output logic [3:0] cmd,
  output logic       conflict,
  output logic       cmd_chg
);

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..65535");
  end

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] next_cmd;
  logic       next_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

`ifdef VAC_CMD_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [4];
  logic [3:0]    stable_q;

  // Any sample agreeing with the accepted level restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s2[i] == stable_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_q[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign sw_stable = stable_q;
`else
  assign sw_stable = s2;
`endif

  // power_off > evading > cleaning > on
  always_comb begin
    next_cmd = '0;
    if (sw_stable[0])      next_cmd = 4'b0001;
    else if (sw_stable[3]) next_cmd = 4'b1000;
    else if (sw_stable[2]) next_cmd = 4'b0100;
    else if (sw_stable[1]) next_cmd = 4'b0010;
  end

  always_comb begin
    next_conflict = ($countones(sw_stable) > 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      conflict <= 1'b0;
      cmd_chg  <= 1'b0;
    end else begin
      cmd      <= next_cmd;
      conflict <= next_conflict;
      cmd_chg  <= (next_cmd != cmd);
    end
  end

endmodule

// File: tb/tb_vac_cmd_conditioner.sv
// Directed self-checking bench for vac_cmd_conditioner (DEBOUNCE_CYCLES=4); expected
// latencies follow `VAC_CMD_DEBOUNCE_EN.
module tb_vac_cmd_conditioner;

  localparam int DB = 4;
`ifdef VAC_CMD_DEBOUNCE_EN
  localparam int ACC = 2 + DB;
`else
  localparam int ACC = 2;
`endif
  localparam int CMD_E = ACC + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_in;
  logic [3:0] sw_stable;
  logic [3:0] cmd;
  logic       conflict;
  logic       cmd_chg;

  int n_checks = 0;
  int n_fail   = 0;

  vac_cmd_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .sw_stable (sw_stable),
    .cmd       (cmd),
    .conflict  (conflict),
    .cmd_chg   (cmd_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] v);
    sw_in = v;
    repeat (CMD_E + 2) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_cmd;
    logic       exp_conf;
    rst_n = 1'b0;
    sw_in = 4'b0000;
    repeat (3) step();
    n_checks++;
    if ({sw_stable, cmd, conflict, cmd_chg} !== 10'b0) begin
      n_fail++;
      $display("FAIL por_state actual %b required %b", {sw_stable, cmd, conflict, cmd_chg}, 10'b0);
    end
    rst_n = 1'b1;
    settle(4'b1111);
    n_checks++;
    if ({cmd, conflict} !== 5'b0001_1) begin
      n_fail++;
      $display("FAIL reset_pre actual %b required %b", {cmd, conflict}, 5'b0001_1);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sw_stable, cmd, conflict, cmd_chg} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset actual %b required %b", {sw_stable, cmd, conflict, cmd_chg}, 10'b0);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= CMD_E; e++) begin
      step();
      exp_cmd  = (e == CMD_E) ? 4'b0001 : 4'b0000;
      exp_conf = (e == CMD_E);
      n_checks++;
      if ({cmd, conflict} !== {exp_cmd, exp_conf}) begin
        n_fail++;
        $display("FAIL reset_reaccept edge %0d actual %b required %b", e, {cmd, conflict}, {exp_cmd, exp_conf});
      end
    end
    settle(4'b0000);
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_st;
    logic [3:0] exp_cmd;
    int pulses = 0;
    sw_in = 4'b0010;
    for (int e = 1; e <= CMD_E + 3; e++) begin
      step();
      exp_st  = (e >= ACC) ? 4'b0010 : 4'b0000;
      exp_cmd = (e >= CMD_E) ? 4'b0010 : 4'b0000;
      if (cmd_chg) pulses++;
      n_checks++;
      if ({sw_stable, cmd, cmd_chg} !== {exp_st, exp_cmd, (e == CMD_E)}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d actual %b required %b", e, {sw_stable, cmd, cmd_chg},
                 {exp_st, exp_cmd, (e == CMD_E)});
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL clean_press_pulses actual %0d required 1", pulses);
    end
    settle(4'b0000);
  endtask

`ifdef VAC_CMD_DEBOUNCE_EN
  task automatic test_bounce();
    for (int e = 0; e < 50; e++) begin
      sw_in = (e < 40 && ((e / 2) % 2 == 0)) ? 4'b0100 : 4'b0000;
      step();
      n_checks++;
      if ({sw_stable, cmd, cmd_chg} !== 9'b0) begin
        n_fail++;
        $display("FAIL bounce edge %0d actual %b required %b", e, {sw_stable, cmd, cmd_chg}, 9'b0);
      end
    end
  endtask
`else
  task automatic test_glitch();
    logic [3:0] exp_st;
    logic [3:0] exp_cmd;
    sw_in = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      step();
      sw_in   = 4'b0000;
      exp_st  = (e == 2) ? 4'b0100 : 4'b0000;
      exp_cmd = (e == 3) ? 4'b0100 : 4'b0000;
      n_checks++;
      if ({sw_stable, cmd, cmd_chg} !== {exp_st, exp_cmd, (e == 3 || e == 4)}) begin
        n_fail++;
        $display("FAIL glitch edge %0d actual %b required %b", e, {sw_stable, cmd, cmd_chg},
                 {exp_st, exp_cmd, (e == 3 || e == 4)});
      end
    end
  endtask
`endif

  task automatic test_priority();
    logic [3:0] exp_cmd;
    settle(4'b0110);
    n_checks++;
    if ({cmd, conflict} !== 5'b0100_1) begin
      n_fail++;
      $display("FAIL prio_on_clean actual %b required %b", {cmd, conflict}, 5'b0100_1);
    end
    sw_in = 4'b1110;
    for (int e = 1; e <= CMD_E + 2; e++) begin
      step();
      exp_cmd = (e >= CMD_E) ? 4'b1000 : 4'b0100;
      n_checks++;
      if ({cmd, conflict, cmd_chg} !== {exp_cmd, 1'b1, (e == CMD_E)}) begin
        n_fail++;
        $display("FAIL prio_evading edge %0d actual %b required %b", e, {cmd, conflict, cmd_chg},
                 {exp_cmd, 1'b1, (e == CMD_E)});
      end
    end
    sw_in = 4'b1111;
    for (int e = 1; e <= CMD_E + 2; e++) begin
      step();
      exp_cmd = (e >= CMD_E) ? 4'b0001 : 4'b1000;
      n_checks++;
      if ({cmd, conflict, cmd_chg} !== {exp_cmd, 1'b1, (e == CMD_E)}) begin
        n_fail++;
        $display("FAIL prio_power_off edge %0d actual %b required %b", e, {cmd, conflict, cmd_chg},
                 {exp_cmd, 1'b1, (e == CMD_E)});
      end
    end
    sw_in = 4'b1011;
    for (int e = 1; e <= CMD_E + 2; e++) begin
      step();
      n_checks++;
      if ({cmd, conflict, cmd_chg} !== 6'b0001_1_0) begin
        n_fail++;
        $display("FAIL prio_release_clean edge %0d actual %b required %b", e, {cmd, conflict, cmd_chg}, 6'b0001_1_0);
      end
    end
    n_checks++;
    if (sw_stable !== 4'b1011) begin
      n_fail++;
      $display("FAIL prio_stable actual %b required %b", sw_stable, 4'b1011);
    end
    settle(4'b0000);
    n_checks++;
    if ({cmd, conflict} !== 5'b0) begin
      n_fail++;
      $display("FAIL prio_idle actual %b required %b", {cmd, conflict}, 5'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st;
    logic [3:0] exp_cmd;
    int pulses = 0;
    sw_in = 4'b1100;
    for (int e = 1; e <= CMD_E + 3; e++) begin
      step();
      exp_st  = (e >= ACC) ? 4'b1100 : 4'b0000;
      exp_cmd = (e >= CMD_E) ? 4'b1000 : 4'b0000;
      if (cmd_chg) pulses++;
      n_checks++;
      if ({sw_stable, cmd, conflict} !== {exp_st, exp_cmd, (e >= CMD_E)}) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d actual %b required %b", e, {sw_stable, cmd, conflict},
                 {exp_st, exp_cmd, (e >= CMD_E)});
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL simultaneous_pulses actual %0d required 1", pulses);
    end
    settle(4'b0000);
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] exp_cmd;
    sw_in = 4'b0010;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({sw_stable, cmd} !== 8'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear actual %b required %b", {sw_stable, cmd}, 8'b0);
    end
    #2 rst_n = 1'b1;
    for (int e = 1; e <= CMD_E + 1; e++) begin
      step();
      exp_cmd = (e >= CMD_E) ? 4'b0010 : 4'b0000;
      n_checks++;
      if ({cmd, cmd_chg} !== {exp_cmd, (e == CMD_E)}) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d actual %b required %b", e, {cmd, cmd_chg}, {exp_cmd, (e == CMD_E)});
      end
    end
    settle(4'b0000);
  endtask

  initial begin
    test_reset();
    test_clean_press();
`ifdef VAC_CMD_DEBOUNCE_EN
    test_bounce();
`else
    test_glitch();
`endif
    test_priority();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vac_cmd_conditioner.md
# vac_cmd_conditioner

Input conditioning stage for the vacuum-robot controller. It takes the four raw slide switches (power_off, on, cleaning, evading) and synchronizes and debounces each one. It then resolves them into a single prioritized one-hot command that feeds the Moore state machine directly. It sits between the top-level `ui_in[3:0]` pins and the FSM command inputs, and also flags conflicting switch settings and command changes.

## Interface
- `DEBOUNCE_CYCLES`, default 20000 (2 ms at 10 MHz): consecutive stable synchronized samples required before a switch change is accepted; legal range 1..65535.
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw_in`  in  4  raw switches, asynchronous to `clk`.
  - Bit 0 is power_off, bit 1 on, bit 2 cleaning, bit 3 evading.
- `sw_stable`  out  4  debounced switch levels, same bit map.
- `cmd`  out  4  registered one-hot command to the FSM, same bit map; 4'b0000 when no switch is active.
- `conflict`  out  1  registered; high while more than one bit of `sw_stable` is set.
- `cmd_chg`  out  1  one-cycle pulse on the cycle `cmd` takes a new value.

## Operation
- **Synchronizer**
  - Per-bit two-flop synchronizer: `sw_in` → `s1` → `s2`.
  - No logic between the two flops.
- **Debounce**, per channel, with counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - If `s2` == `sw_stable`[i]: `cnt` ← 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES`-1: `sw_stable`[i] ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples clears the counter and is never accepted.
  - The counter saturates by construction and never wraps.
- **Priority encode**, combinational from `sw_stable`, then registered:
  - Priority: power_off > evading > cleaning > on.
  - `cmd` is always zero-hot or one-hot. It is never multi-hot, even during transitions.
- **Conflict**
  - `conflict` ← (popcount(`sw_stable`) ≥ 2), registered alongside `cmd`.
  - The command is still issued per priority while `conflict` is high.
- **Change pulse**
  - `cmd_chg` ← (`next_cmd` != `cmd`), registered, so it is coincident with the first cycle of the new `cmd`.
  - A change in `sw_stable` that does not alter the winning command raises no pulse.
- **Simultaneous changes**
  - Channels debounce independently.
  - Two switches accepted on the same edge produce one `cmd` update and one pulse.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - `s1`, `s2`, `cnt`, `sw_stable`, `cmd`, `conflict` and `cmd_chg` all clear to 0 immediately, independent of `clk`.
  - Release is sampled on the next rising edge.
  - Reset mid-debounce discards the partial count.
  - If a switch is held high through reset, it is re-accepted a full latency after release.
- **Latency**
  - From the first edge that samples a clean `sw_in` level change to the resulting `cmd` change: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (output register) rising edges.
  - `sw_stable` updates one edge before `cmd`.
- **Throughput**: one accepted change per channel at most every `DEBOUNCE_CYCLES` cycles.
- **Handshake**: none. `cmd` is a level held until the switches change, and the FSM samples it every cycle.

## Configuration
- Macro: `VAC_CMD_DEBOUNCE_EN`.
- **Defined**: debounce counters are present as described. Latency is 3+`DEBOUNCE_CYCLES` edges.
- **Undefined**:
  - Counters are not instantiated and `sw_stable` = `s2` directly.
  - Latency is 3 edges and `DEBOUNCE_CYCLES` is ignored.
  - Priority, conflict and pulse logic are unchanged.
  - Intended for simulation and for FPGA boards with hardware-debounced switches.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with the macro defined unless noted.
1. **Reset**: assert `rst_n`=0 mid-cycle with `sw_in`=4'b1111. Outputs go to 0 with no clock edge. After release, `cmd`=4'b0001 and `conflict`=1 on the 7th edge.
2. **Clean press**: `sw_in` 0000→0010 held. `sw_stable`=0010 at edge 6, `cmd`=0010 at edge 7, `cmd_chg`=1 for exactly edge 7 only.
3. **Bounce**: `sw_in`[2] toggles every 2 cycles for 40 cycles, then returns to 0. `sw_stable`, `cmd` and `cmd_chg` never change.
4. **Priority and conflict**:
   - With on+cleaning held (`cmd`=0100, `conflict`=1), add evading: `cmd`=1000 with one pulse.
   - Then add power_off: `cmd`=0001 with one pulse.
   - Releasing cleaning while power_off is still held: no pulse, `cmd` stays 0001.
5. **Reset mid-debounce**: press `sw_in`[1], then pulse `rst_n` low at edge 4. `cmd` stays 0 until edge 7 after release and becomes 0010 then.
6. **Macro undefined**: same stimulus as scenario 2. `cmd`=0010 and the pulse occur at edge 3, and a 1-cycle glitch on `sw_in` does propagate.
